// File: rtl/zap_ram_fifo_ctrl.sv
// FIFO controller wrapped around a 2-cycle pipelined simple dual-port RAM.
// Reads are issued ahead of demand into a 4-entry flop buffer, so the pop side sees registered data.
module zap_ram_fifo_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_wr_valid,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_wr_ready,
    output logic                       o_rd_valid,
    output logic [WIDTH-1:0]           o_rd_data,
    input  logic                       i_rd_ready,
    output logic [$clog2(DEPTH)+1:0]   o_level,
    output logic                       o_ram_clken,
    output logic                       o_ram_wr_en,
    output logic [$clog2(DEPTH)-1:0]   o_ram_wr_addr,
    output logic [WIDTH-1:0]           o_ram_wr_data,
    output logic [$clog2(DEPTH)-1:0]   o_ram_rd_addr,
    input  logic [WIDTH-1:0]           i_ram_rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 2;

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      ram_occ_q, ram_occ_d;
    logic [AW:0]      unread_q, unread_d;
    logic [1:0]       inflight_q;
    logic [WIDTH-1:0] buf_mem_q [4];
    logic [1:0]       buf_head_q, buf_tail_q;
    logic [2:0]       buf_count_q, buf_count_d;
    logic [2:0]       buf_reserved;
    logic             push, pop, issue, land;

    assign o_wr_ready = (ram_occ_q != (AW+1)'(DEPTH));
    assign o_rd_valid = (buf_count_q != 3'd0);
    assign o_rd_data  = buf_mem_q[buf_head_q];

    assign push = i_wr_valid && o_wr_ready && !i_clear;
    assign pop  = o_rd_valid && i_rd_ready && !i_clear;
    assign land = inflight_q[1] && !i_clear;

    // Buffer slots are reserved at issue time so a landing word always has a home.
    assign buf_reserved = buf_count_q + {2'b00, inflight_q[0]} + {2'b00, inflight_q[1]};
    assign issue        = (unread_q != '0) && (buf_reserved < 3'd4) && !i_clear;

    assign o_ram_clken   = 1'b1;
    assign o_ram_wr_en   = push;
    assign o_ram_wr_addr = wr_ptr_q;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_addr = rd_ptr_q;

    assign o_level = LW'(ram_occ_q) + LW'(buf_count_q);

    always_comb begin
        unread_d = unread_q;
        if (push && !issue) begin
            unread_d = unread_q + (AW+1)'(1);
        end else if (!push && issue) begin
            unread_d = unread_q - (AW+1)'(1);
        end

        // A RAM slot is released only when its word lands, never at issue.
        ram_occ_d = ram_occ_q;
        if (push && !land) begin
            ram_occ_d = ram_occ_q + (AW+1)'(1);
        end else if (!push && land) begin
            ram_occ_d = ram_occ_q - (AW+1)'(1);
        end

        buf_count_d = buf_count_q;
        if (land && !pop) begin
            buf_count_d = buf_count_q + 3'd1;
        end else if (!land && pop) begin
            buf_count_d = buf_count_q - 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_occ_q   <= '0;
            unread_q    <= '0;
            inflight_q  <= '0;
            buf_head_q  <= '0;
            buf_tail_q  <= '0;
            buf_count_q <= '0;
        end else if (i_clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_occ_q   <= '0;
            unread_q    <= '0;
            inflight_q  <= '0;
            buf_head_q  <= '0;
            buf_tail_q  <= '0;
            buf_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (land) begin
                buf_tail_q <= buf_tail_q + 2'd1;
            end
            if (pop) begin
                buf_head_q <= buf_head_q + 2'd1;
            end
            ram_occ_q   <= ram_occ_d;
            unread_q    <= unread_d;
            inflight_q  <= {inflight_q[0], issue};
            buf_count_q <= buf_count_d;
        end
    end

    // Buffer storage needs no reset; validity comes from buf_count_q.
    always_ff @(posedge i_clk) begin
        if (land) begin
            buf_mem_q[buf_tail_q] <= i_ram_rd_data;
        end
    end

endmodule

// File: tb/tb_zap_ram_fifo_ctrl.sv
// Directed bench for zap_ram_fifo_ctrl with a behavioural 2-cycle pipelined RAM.
module tb_zap_ram_fifo_ctrl;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_clear;
    logic          i_wr_valid;
    logic [W-1:0]  i_wr_data;
    logic          o_wr_ready;
    logic          o_rd_valid;
    logic [W-1:0]  o_rd_data;
    logic          i_rd_ready;
    logic [AW+1:0] o_level;
    logic          o_ram_clken;
    logic          o_ram_wr_en;
    logic [AW-1:0] o_ram_wr_addr;
    logic [W-1:0]  o_ram_wr_data;
    logic [AW-1:0] o_ram_rd_addr;
    logic [W-1:0]  i_ram_rd_data;

    always #5 i_clk = ~i_clk;

    zap_ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_clear       (i_clear),
        .i_wr_valid    (i_wr_valid),
        .i_wr_data     (i_wr_data),
        .o_wr_ready    (o_wr_ready),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .i_rd_ready    (i_rd_ready),
        .o_level       (o_level),
        .o_ram_clken   (o_ram_clken),
        .o_ram_wr_en   (o_ram_wr_en),
        .o_ram_wr_addr (o_ram_wr_addr),
        .o_ram_wr_data (o_ram_wr_data),
        .o_ram_rd_addr (o_ram_rd_addr),
        .i_ram_rd_data (i_ram_rd_data)
    );

    // RAM model: address registered, then data registered (valid 2 clocks after address).
    logic [W-1:0]  ram_mem [D];
    logic [AW-1:0] ram_addr_q;
    always @(posedge i_clk) begin
        if (o_ram_wr_en) ram_mem[o_ram_wr_addr] <= o_ram_wr_data;
        ram_addr_q    <= o_ram_rd_addr;
        i_ram_rd_data <= ram_mem[ram_addr_q];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
        chk({tag, "_wr_en"}, 64'(o_ram_wr_en), 64'd0);
        chk({tag, "_level"}, 64'(o_level), 64'd0);
        chk({tag, "_wr_ready"}, 64'(o_wr_ready), 64'd1);
        chk({tag, "_wr_addr"}, 64'(o_ram_wr_addr), 64'd0);
        chk({tag, "_rd_addr"}, 64'(o_ram_rd_addr), 64'd0);
    endtask

    logic [W-1:0] sb [$];
    logic [W-1:0] exp_w;
    int accepted;
    int guard;

    initial begin
        i_reset_n  = 1'b0;
        i_clear    = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_rd_ready = 1'b0;
        #1;
        chk_reset_outputs("rst");
        chk("rst_clken", 64'(o_ram_clken), 64'd1);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // Single word latency: push cycle 0, issue cycle 1, valid cycle 4.
        i_wr_valid = 1'b1;
        i_wr_data  = 32'hA5A5_0001;
        i_rd_ready = 1'b1;
        #1;
        chk("lat_wr_en", 64'(o_ram_wr_en), 64'd1);
        chk("lat_wr_addr", 64'(o_ram_wr_addr), 64'd0);
        chk("lat_wr_data", 64'(o_ram_wr_data), 64'hA5A5_0001);
        tick();
        i_wr_valid = 1'b0;
        #1;
        chk("lat_c1_rd_addr", 64'(o_ram_rd_addr), 64'd0);
        chk("lat_c1_level", 64'(o_level), 64'd1);
        tick();
        #1;
        chk("lat_c2_rd_addr", 64'(o_ram_rd_addr), 64'd1);
        chk("lat_c2_valid", 64'(o_rd_valid), 64'd0);
        tick();
        #1;
        chk("lat_c3_valid", 64'(o_rd_valid), 64'd0);
        tick();
        #1;
        chk("lat_c4_valid", 64'(o_rd_valid), 64'd1);
        chk("lat_c4_data", 64'(o_rd_data), 64'hA5A5_0001);
        tick();
        #1;
        chk("lat_c5_valid", 64'(o_rd_valid), 64'd0);
        chk("lat_c5_level", 64'(o_level), 64'd0);
        tick();

        // Fill with no pops: 32 in RAM plus 4 in the buffer.
        i_rd_ready = 1'b0;
        accepted   = 0;
        for (int i = 0; i < 40; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 32'(i);
            #1;
            chk("full_ready", 64'(o_wr_ready), 64'(i < 36));
            if (o_wr_ready) accepted++;
            tick();
        end
        i_wr_valid = 1'b0;
        #1;
        chk("full_accepted", 64'(accepted), 64'd36);
        chk("full_level", 64'(o_level), 64'd36);
        chk("full_ready_low", 64'(o_wr_ready), 64'd0);
        tick();
        i_rd_ready = 1'b1;
        for (int j = 0; j < 36; j++) begin
            #1;
            if (j < 6) chk("drain_ready", 64'(o_wr_ready), 64'(j >= 4));
            chk("drain_valid", 64'(o_rd_valid), 64'd1);
            chk("drain_data", 64'(o_rd_data), 64'(j));
            tick();
        end
        #1;
        chk("drain_end_valid", 64'(o_rd_valid), 64'd0);
        chk("drain_end_level", 64'(o_level), 64'd0);
        tick();

        // Streaming: one word per cycle after 4-cycle latency, pointers wrap.
        for (int c = 0; c < 104; c++) begin
            i_wr_valid = (c < 100);
            i_wr_data  = 32'(1000 + c);
            i_rd_ready = 1'b1;
            #1;
            if (c < 4) begin
                chk("stream_lead_valid", 64'(o_rd_valid), 64'd0);
            end else begin
                chk("stream_valid", 64'(o_rd_valid), 64'd1);
                chk("stream_data", 64'(o_rd_data), 64'(1000 + c - 4));
            end
            tick();
        end
        i_wr_valid = 1'b0;
        #1;
        chk("stream_end_level", 64'(o_level), 64'd0);
        tick();

        // Random back-pressure against a scoreboard.
        for (int c = 0; c < 300; c++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = $urandom;
            i_rd_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rand_level", 64'(o_level), 64'(sb.size()));
            if (o_wr_ready) sb.push_back(i_wr_data);
            if (o_rd_valid && i_rd_ready) begin
                exp_w = sb.pop_front();
                chk("rand_data", 64'(o_rd_data), 64'(exp_w));
            end
            tick();
        end
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b1;
        guard      = 0;
        while (sb.size() > 0 && guard < 200) begin
            #1;
            if (o_rd_valid) begin
                exp_w = sb.pop_front();
                chk("rand_drain_data", 64'(o_rd_data), 64'(exp_w));
            end
            tick();
            guard++;
        end
        #1;
        chk("rand_drain_left", 64'(sb.size()), 64'd0);
        chk("rand_drain_level", 64'(o_level), 64'd0);
        chk("rand_drain_valid", 64'(o_rd_valid), 64'd0);
        tick();

        // Synchronous clear with data held and a push offered in the same cycle.
        i_rd_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 32'(200 + c);
            tick();
        end
        i_wr_valid = 1'b0;
        repeat (6) tick();
        #1;
        chk("clr_pre_level", 64'(o_level), 64'd10);
        i_clear    = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 32'hDEAD;
        i_rd_ready = 1'b1;
        #1;
        chk("clr_wr_ready", 64'(o_wr_ready), 64'd1);
        tick();
        i_clear    = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data  = 32'h1234;
        #1;
        chk("clr_valid", 64'(o_rd_valid), 64'd0);
        chk("clr_level", 64'(o_level), 64'd0);
        chk("clr_wr_addr", 64'(o_ram_wr_addr), 64'd0);
        tick();
        i_wr_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            #1;
            if (c < 4) chk("clr_new_lead", 64'(o_rd_valid), 64'd0);
            else begin
                chk("clr_new_valid", 64'(o_rd_valid), 64'd1);
                chk("clr_new_data", 64'(o_rd_data), 64'h1234);
            end
            tick();
        end
        #1;
        chk("clr_end_level", 64'(o_level), 64'd0);
        tick();

        // Asynchronous reset with two reads in flight.
        i_rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 32'(300 + c);
            tick();
        end
        i_wr_valid = 1'b0;
        #2;
        i_reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
        i_rd_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("arst_stale_valid", 64'(o_rd_valid), 64'd0);
            tick();
        end
        i_wr_valid = 1'b1;
        i_wr_data  = 32'h7777;
        #1;
        chk("arst_wr_addr", 64'(o_ram_wr_addr), 64'd0);
        tick();
        i_wr_valid = 1'b0;
        repeat (3) tick();
        #1;
        chk("arst_new_valid", 64'(o_rd_valid), 64'd1);
        chk("arst_new_data", 64'(o_rd_data), 64'h7777);
        tick();
        #1;
        chk("arst_end_level", 64'(o_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
